// File: rtl/board_scan_driver_if.sv
// Control and display-side signals of the LED board scan driver.
// The master drives enable/board; the slave (the driver) produces the scan outputs.
interface board_scan_driver_if;
    logic             enable;
    logic [7:0][23:0] board;
    logic             shift_clk;
    logic             shift_data;
    logic             shift_latch;
    logic [7:0]       row_select;
    logic             frame_done;
    logic             busy;

    modport master (
        output enable, board,
        input  shift_clk, shift_data, shift_latch, row_select, frame_done, busy
    );

    modport slave (
        input  enable, board,
        output shift_clk, shift_data, shift_latch, row_select, frame_done, busy
    );
endinterface

// File: rtl/board_scan_driver.sv
// Multiplexed 8-row LED board scanner: shifts 24 column bits per row, latches them,
// then lights the row for HOLD_CYCLES clocks. The frame is snapshotted at row 0.
module board_scan_driver #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset_n,
    board_scan_driver_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD} state_e;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0][23:0] fbuf_q, fbuf_d;
    logic [23:0]      sreg_q, sreg_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       row_q, row_d;
    logic [7:0]       phase_q, phase_d;
    logic [15:0]      hold_q, hold_d;

    logic       shift_clk_q, shift_clk_d;
    logic       shift_data_q, shift_data_d;
    logic       shift_latch_q, shift_latch_d;
    logic [7:0] row_sel_q, row_sel_d;
    logic       frame_done_q, frame_done_d;
    logic       busy_q, busy_d;

    logic phase_last;
    assign phase_last = (phase_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        fbuf_d    = fbuf_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        row_d     = row_q;
        phase_d   = '0;
        hold_d    = '0;

        case (state_q)
            IDLE: begin
                row_d = '0;
                if (bus.enable) state_d = LOAD;
            end
            LOAD: begin
                // Row 0 takes its data straight from the board being snapshotted.
                if (row_q == 3'd0) begin
                    fbuf_d = bus.board;
                    sreg_d = bus.board[0];
                end else begin
                    sreg_d = fbuf_q[row_q];
                end
                bit_cnt_d = '0;
                state_d   = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (phase_last) state_d = SHIFT_HI;
                else            phase_d = phase_q + 8'd1;
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    sreg_d    = {sreg_q[22:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = (bit_cnt_q == 5'd23) ? LATCH : SHIFT_LO;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            LATCH: begin
                if (phase_last) state_d = HOLD;
                else            phase_d = phase_q + 8'd1;
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    if (bus.enable) begin
                        row_d   = row_q + 3'd1;
                        state_d = LOAD;
                    end else begin
                        row_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next state so the registered copies line up with state_q.
        shift_clk_d   = (state_d == SHIFT_HI);
        shift_data_d  = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? sreg_d[23] : 1'b0;
        shift_latch_d = (state_d == LATCH);
        row_sel_d     = (state_d == HOLD) ? (8'd1 << row_d) : 8'd0;
        frame_done_d  = (state_d == HOLD) && (row_d == 3'd7) && (hold_d == HOLD_LAST);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fbuf_q        <= '0;
            sreg_q        <= '0;
            bit_cnt_q     <= '0;
            row_q         <= '0;
            phase_q       <= '0;
            hold_q        <= '0;
            shift_clk_q   <= 1'b0;
            shift_data_q  <= 1'b0;
            shift_latch_q <= 1'b0;
            row_sel_q     <= '0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fbuf_q        <= fbuf_d;
            sreg_q        <= sreg_d;
            bit_cnt_q     <= bit_cnt_d;
            row_q         <= row_d;
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            shift_clk_q   <= shift_clk_d;
            shift_data_q  <= shift_data_d;
            shift_latch_q <= shift_latch_d;
            row_sel_q     <= row_sel_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.shift_clk   = shift_clk_q;
    assign bus.shift_data  = shift_data_q;
    assign bus.shift_latch = shift_latch_q;
    assign bus.row_select  = row_sel_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/board_scan_driver.md
BOARD_SCAN_DRIVER -- requirements
Module: board_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per shift-clock phase (low or high); legal range 1..255.
REQ-002 Parameter HOLD_CYCLES, default 1000: system clocks one row stays lit; legal range 1..65535.
REQ-003 clock  input  1  system clock, all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = run the scan, 0 = stop at the next row boundary.
REQ-006 board  input  [7:0][23:0]  row-major frame; row i bits 23..0 = column data for the R, G and B registers, bit 23 shifted first.
REQ-007 shift_clk  output  1  serial clock to the column shift registers; data is sampled on its rising edge.
REQ-008 shift_data  output  1  serial column data.
REQ-009 shift_latch  output  1  storage-register latch strobe, active high.
REQ-010 row_select  output  [7:0]  one-hot row enable, active high.
REQ-011 frame_done  output  1  one-cycle pulse at the end of the row 7 hold.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL use the states IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH and HOLD.
REQ-014 IDLE: outputs SHALL be inactive and row SHALL equal 0; enable=1 -> LOAD on the next cycle.
REQ-015 LOAD (1 cycle): when row==0 the block SHALL snapshot all of board into an internal frame buffer; it SHALL then load the 24-bit shift register from frame buffer row "row" and clear bit_cnt.
REQ-016 The board data used for rows 1..7 SHALL come only from the snapshot; board changes mid-frame SHALL be invisible until the next frame (no tearing).
REQ-017 SHIFT_LO (CLK_DIV cycles): shift_clk=0 and shift_data=sreg[23]; then -> SHIFT_HI.
REQ-018 SHIFT_HI (CLK_DIV cycles): shift_clk=1 and shift_data held. On exit sreg SHALL shift left by 1 and bit_cnt SHALL increment. Next state is LATCH if bit_cnt was 23, else SHIFT_LO.
REQ-019 LATCH (CLK_DIV cycles): shift_latch=1 and shift_clk=0; then -> HOLD.
REQ-020 HOLD (HOLD_CYCLES cycles): row_select SHALL equal 1<<row. The output SHALL be 0 in every other state, which blanks the row during the shift.
REQ-021 On HOLD exit, row SHALL advance modulo 8 (7 -> 0), and frame_done SHALL pulse for exactly 1 cycle when the exiting row is 7.
REQ-022 On HOLD exit the block SHALL go to LOAD if enable=1. If enable=0 it SHALL go to IDLE and row SHALL reset to 0.
REQ-023 enable deasserted in any non-IDLE state SHALL NOT abort the row; the current row SHALL finish through HOLD.
REQ-024 Row period SHALL be 1 + 49*CLK_DIV + HOLD_CYCLES cycles, i.e. 1197 cycles with the defaults; frame period SHALL be 8x the row period.
REQ-025 Exactly 24 shift_clk rising edges SHALL occur per row, and exactly 1 shift_latch pulse per row, after the 24th edge.
REQ-026 Phase counter width SHALL be 8 bits and hold counter width SHALL be 16 bits; both SHALL reload to 0 on each state entry.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 When reset_n=0, the block SHALL enter IDLE immediately, with row=0, bit_cnt=0, sreg=0, frame buffer=0, and all outputs 0.
REQ-029 Reset asserted mid-shift or mid-hold SHALL abort at once: row_select=0 and shift_latch=0 with no glitch pulse.
REQ-030 After reset_n rises with enable=1, the first LOAD SHALL occur on the second rising clock edge and SHALL snapshot board.

Verification
REQ-031 Defaults; board row0=24'hA5F00F, enable=1. Required: the 24 bits sampled at shift_clk rising edges equal A5F00F, MSB first; one latch pulse follows; row_select=8'h01 for exactly 1000 cycles.
REQ-032 Full frame, rows 0..7 distinct. Required: row_select steps 01,02,04,...,80,01; frame_done pulses once per 9576 cycles, coincident with the end of the row 7 hold.
REQ-033 Change board during the row 3 shift. Required: rows 3..7 show the old data; the new data appears from row 0 of the next frame.
REQ-034 Drop enable during the row 5 SHIFT_HI. Required: row 5 completes its latch and 1000-cycle hold, then IDLE with busy=0 and row_select=0; re-enable starts at row 0.
REQ-035 Assert reset_n=0 during the row 2 HOLD. Required: the same cycle shows row_select=0 and outputs 0; after release the scan restarts at row 0.
REQ-036 CLK_DIV=1, HOLD_CYCLES=1. Required: row period of 51 cycles, 24 shift edges, and shift_clk high and low phases of 1 cycle each.
